calib_bitplane_fsm: RTL
=======================

# calib_bitplane_fsm

Multi-plane LED calibration sequencer with an integrated shift-accumulate frame store. For each of `LED_ADDRESS_WIDTH` binary bit planes it requests an LED pattern from the strand driver, waits for the strand to settle, and captures `FRAMES_PER_PLANE` camera frames. Each downsampled pixel's per-plane detection is shifted into a per-pixel word, so after one run each word holds the ID of the LED seen at that pixel. It sits between the camera/detector pipeline and the LED strand driver, and the host reads IDs back after `done`.

## Interface
Parameters:
- `LED_ADDRESS_WIDTH`, default 10: bit planes per run and word width.
- `WAIT_CYCLES`, default 10000000: settle cycles after strand valid, ≥ 1.
- `ACTIVE_H_PIXELS`, default 320: active width.
- `ACTIVE_LINES`, default 180: active height.
- `DOWNSAMPLE_SHIFT`, default 2: log2 of the downsample factor, ≥ 1.
- `FRAMES_PER_PLANE`, default 2: frames combined per plane, ≥ 1.
- Derived: `DEPTH = (ACTIVE_H_PIXELS>>DOWNSAMPLE_SHIFT)*(ACTIVE_LINES>>DOWNSAMPLE_SHIFT)`; `AW = $clog2(DEPTH)`; `PW = $clog2(LED_ADDRESS_WIDTH+1)`.

Ports:
- `clk_pixel` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level input; a rising edge starts a run.
- `displayed_frame_valid` in 1: strand driver is showing the requested plane.
- `hcount_in` in 11, `vcount_in` in 10: pixel coordinates aligned with `detect_in`.
- `new_frame_in` in 1: single-cycle start-of-frame pulse.
- `detect_in` in 1: detector output for the current pixel.
- `read_request` in 1: host read strobe.
- `read_addr` in AW: host read word address.
- `state` out 3: current FSM state.
- `plane_idx` out PW: plane currently requested.
- `plane_request` out 1: one-cycle pulse asking the driver to show `plane_idx`.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: one-cycle pulse when the last plane completes.
- `read_valid` out 1: `read_out` is valid.
- `read_out` out LED_ADDRESS_WIDTH: word read back.

## Operation
- States, in encoding order: IDLE=0, REQUEST_PLANE=1, WAIT_FOR_LED_STRAND_VALID=2, WAIT_FOR_CAM=3, WAIT_FOR_NFRAME=4, CAPTURE_FRAME=5, DONE=6.
- **IDLE/DONE:**
  - A `start` rising edge clears `plane_idx` and goes to REQUEST_PLANE.
  - Start edges in any other state are ignored.
- **REQUEST_PLANE:** pulses `plane_request` for one cycle, then goes to WAIT_FOR_LED_STRAND_VALID.
- **WAIT_FOR_LED_STRAND_VALID:** on `displayed_frame_valid`, clears the wait counter and goes to WAIT_FOR_CAM.
- **WAIT_FOR_CAM:** increments the counter each cycle; at `WAIT_CYCLES-1` goes to WAIT_FOR_NFRAME.
- **WAIT_FOR_NFRAME:** on `new_frame_in`, clears the frame counter and goes to CAPTURE_FRAME.
- **CAPTURE_FRAME:** each `new_frame_in` ends a frame.
  - If frame count < `FRAMES_PER_PLANE-1`: increment the frame count and stay.
  - Else, if this is the last plane: go to DONE and pulse `done`.
  - Else: `plane_idx++` and go to REQUEST_PLANE.
- **Sampling:** a pixel is sampled when it is active (`hcount_in<ACTIVE_H_PIXELS`, `vcount_in<ACTIVE_LINES`) and both coordinates have their low DOWNSAMPLE_SHIFT bits equal to zero.
  - Sampled address = `(hcount>>S) + (ACTIVE_H_PIXELS>>S)*(vcount>>S)`.
- **Read-modify-write per sample:** cycle 0 reads the word; cycle 1 writes it back.
  - First frame of a plane: write `{old[W-2:0], detect}`.
  - Later frames: the LSB is combined with `detect` per Configuration.
  - Plane 0, first frame: write `{(W-1)'b0, detect}`. No memory clear is needed.
- **Result:** after a run, bit W-1-p holds plane p, i.e. plane 0 lands in the MSB. The driver lights the LEDs whose ID bit W-1-p is 1.
- **Host reads:** honoured only in IDLE/DONE and ignored otherwise. They never stall capture.
- **Reset:**
  - Outputs: `state`=IDLE, `plane_idx`=0, `plane_request`=0, `busy`=0, `done`=0, `read_valid`=0, `read_out`=0.
  - The memory contents are not reset.
  - Reset mid-run abandons the run; no `done` is produced.
  - An RMW in flight when `rst` rises is dropped.

## Timing
- `plane_request` is asserted in the cycle after entry to REQUEST_PLANE.
- The pipeline has 1 cycle from sample to write, which is safe because samples are ≥ 2 cycles apart.
- RMW data hazard: the read path forwards the pending write when addresses match.
- `read_valid`/`read_out` appear 2 cycles after `read_request` and are held for 1 cycle.
- `new_frame_in` in the same cycle as a sample: the sample belongs to the frame being ended.
- CAPTURE_FRAME→REQUEST_PLANE: pixels arriving between planes are not sampled.

## Configuration
- `CALIB_AND_VOTE_EN` defined: later frames write LSB = `old[0] & detect`, so a bit is set only if it was detected in every frame of the plane.
- Undefined: later frames write LSB = `old[0] | detect`, so a bit is set if it was detected in any frame.

## Test plan
- W=4, S=2, 16x8, WAIT_CYCLES=3, FRAMES_PER_PLANE=1. Detect asserted only at pixel (4,0) on planes 0 and 2 → read addr 1 returns 4'b1010; every other address returns 0.
- FRAMES_PER_PLANE=2, pixel detected only in frame 0 of plane 0 → MSB=1 without the macro, 0 with `CALIB_AND_VOTE_EN`.
- `start` held high for 10 cycles → exactly one run and 4 `plane_request` pulses; `done` pulses once and `state`=6.
- `rst` asserted during CAPTURE_FRAME of plane 2 → next cycle `state`=0, `plane_idx`=0, `busy`=0; no `done`.
- `read_request` during WAIT_FOR_CAM → no `read_valid`; the same request in DONE → `read_valid` exactly 2 cycles later.
- `displayed_frame_valid` delayed 50 cycles → settle count starts only after it rises; WAIT_FOR_NFRAME is entered exactly WAIT_CYCLES cycles later.

Source files
------------

// File: rtl/calib_bitplane_fsm.sv
// ---------------------------------------------------------------------------
// calib_bitplane_fsm
//
// Multi-plane LED calibration sequencer with a shift-accumulate frame store.
// For each of LED_ADDRESS_WIDTH binary bit planes the sequencer asks the strand
// driver for a pattern, waits for the strand to settle, then captures
// FRAMES_PER_PLANE camera frames. Every downsampled pixel gets one word; each
// plane's detection is shifted into that word, so after a run the word holds
// the ID of the LED seen at that pixel (plane 0 ends up in the MSB).
//
// Build option:
//   CALIB_AND_VOTE_EN  defined   : later frames AND into the plane bit (all frames must agree)
//                      undefined : later frames OR into the plane bit (any frame suffices)
//
// Ports:
//   clk_pixel              single clock
//   rst                    synchronous active-high reset
//   start                  level; a rising edge in IDLE/DONE starts a run
//   displayed_frame_valid  strand driver is showing the requested plane
//   hcount_in/vcount_in    pixel coordinates aligned with detect_in
//   new_frame_in           one-cycle start-of-frame pulse
//   detect_in              detector output for the current pixel
//   read_request/read_addr host word read (only honoured in IDLE/DONE)
//   state                  current FSM state (debug/visibility)
//   plane_idx              plane currently requested
//   plane_request          one-cycle pulse asking the driver to show plane_idx
//   busy                   high in every state except IDLE and DONE
//   done                   one-cycle pulse when the last plane completes
//   read_valid/read_out    read data, two cycles after an accepted request
//
// Host read handshake: there is no back-pressure. A read_request sampled while
// the FSM is in IDLE or DONE is accepted; exactly two cycles later read_valid
// is high for one cycle with read_out carrying the word. Requests in any other
// state are dropped silently and never produce read_valid.
// ---------------------------------------------------------------------------
module calib_bitplane_fsm #(
    parameter int LED_ADDRESS_WIDTH = 10,
    parameter int WAIT_CYCLES       = 10000000,
    parameter int ACTIVE_H_PIXELS   = 320,
    parameter int ACTIVE_LINES      = 180,
    parameter int DOWNSAMPLE_SHIFT  = 2,
    parameter int FRAMES_PER_PLANE  = 2,
    localparam int DEPTH = (ACTIVE_H_PIXELS >> DOWNSAMPLE_SHIFT) * (ACTIVE_LINES >> DOWNSAMPLE_SHIFT),
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = $clog2(LED_ADDRESS_WIDTH + 1)
) (
    input  logic                         clk_pixel,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         displayed_frame_valid,
    input  logic [10:0]                  hcount_in,
    input  logic [9:0]                   vcount_in,
    input  logic                         new_frame_in,
    input  logic                         detect_in,
    input  logic                         read_request,
    input  logic [AW-1:0]                read_addr,
    output logic [2:0]                   state,
    output logic [PW-1:0]                plane_idx,
    output logic                         plane_request,
    output logic                         busy,
    output logic                         done,
    output logic                         read_valid,
    output logic [LED_ADDRESS_WIDTH-1:0] read_out
);

    localparam int W    = LED_ADDRESS_WIDTH;
    localparam int S    = DOWNSAMPLE_SHIFT;
    localparam int COLS = ACTIVE_H_PIXELS >> S;
    localparam int WCW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int FCW  = (FRAMES_PER_PLANE > 1) ? $clog2(FRAMES_PER_PLANE) : 1;

    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_CYCLES - 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_PLANE - 1);
    localparam logic [PW-1:0]  PLANE_LAST = PW'(W - 1);
    localparam logic [10:0]    H_LIM      = 11'(ACTIVE_H_PIXELS);
    localparam logic [9:0]     V_LIM      = 10'(ACTIVE_LINES);

    typedef enum logic [2:0] {
        IDLE                      = 3'd0,
        REQUEST_PLANE             = 3'd1,
        WAIT_FOR_LED_STRAND_VALID = 3'd2,
        WAIT_FOR_CAM              = 3'd3,
        WAIT_FOR_NFRAME           = 3'd4,
        CAPTURE_FRAME             = 3'd5,
        DONE                      = 3'd6
    } state_t;

    state_t         state_q, state_n;
    logic [PW-1:0]  plane_q, plane_n;
    logic [WCW-1:0] wait_q, wait_n;
    logic [FCW-1:0] frame_q, frame_n;
    logic           done_q, done_n;
    logic           plane_request_q;
    logic           start_q;
    logic           start_rise;

    // start_q follows start even through reset so a start held high across
    // reset release is not mistaken for a new rising edge.
    always_ff @(posedge clk_pixel) begin
        start_q <= start;
    end

    assign start_rise = start & ~start_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state_q         <= IDLE;
            plane_q         <= '0;
            wait_q          <= '0;
            frame_q         <= '0;
            done_q          <= 1'b0;
            plane_request_q <= 1'b0;
        end else begin
            state_q         <= state_n;
            plane_q         <= plane_n;
            wait_q          <= wait_n;
            frame_q         <= frame_n;
            done_q          <= done_n;
            // Registered, so the pulse appears the cycle after REQUEST_PLANE
            // is entered, with plane_idx already stable.
            plane_request_q <= (state_q == REQUEST_PLANE);
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n = state_q;
        plane_n = plane_q;
        wait_n  = wait_q;
        frame_n = frame_q;
        done_n  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    plane_n = '0;
                    state_n = REQUEST_PLANE;
                end
            end
            REQUEST_PLANE: begin
                state_n = WAIT_FOR_LED_STRAND_VALID;
            end
            WAIT_FOR_LED_STRAND_VALID: begin
                if (displayed_frame_valid) begin
                    wait_n  = '0;
                    state_n = WAIT_FOR_CAM;
                end
            end
            WAIT_FOR_CAM: begin
                if (wait_q == WAIT_LAST) begin
                    state_n = WAIT_FOR_NFRAME;
                end else begin
                    wait_n = wait_q + 1'b1;
                end
            end
            WAIT_FOR_NFRAME: begin
                if (new_frame_in) begin
                    frame_n = '0;
                    state_n = CAPTURE_FRAME;
                end
            end
            CAPTURE_FRAME: begin
                if (new_frame_in) begin
                    if (frame_q != FRAME_LAST) begin
                        frame_n = frame_q + 1'b1;
                    end else if (plane_q == PLANE_LAST) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        plane_n = plane_q + 1'b1;
                        state_n = REQUEST_PLANE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ---------------- Sample selection ----------------
    logic          px_active;
    logic          px_grid;
    logic          sample_hit;
    logic [AW-1:0] sample_addr;

    assign px_active   = (hcount_in < H_LIM) && (vcount_in < V_LIM);
    assign px_grid     = (hcount_in[S-1:0] == '0) && (vcount_in[S-1:0] == '0);
    // Only CAPTURE_FRAME samples; a sample coinciding with new_frame_in still
    // uses the frame/plane bookkeeping of the frame being ended.
    assign sample_hit  = (state_q == CAPTURE_FRAME) && px_active && px_grid;
    assign sample_addr = AW'(hcount_in >> S) + AW'(COLS * (vcount_in >> S));

    // ---------------- Frame store, read-modify-write ----------------
    logic [W-1:0]  mem [DEPTH];

    logic          s1_valid;
    logic [AW-1:0] s1_addr;
    logic          s1_detect;
    logic          s1_first;
    logic          s1_plane0;
    logic [W-1:0]  s1_old;
    logic [W-1:0]  s1_new;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= sample_hit;
        end
    end

    // Cycle 0 of the RMW: capture the old word, forwarding the write that is
    // completing this cycle when it targets the same address.
    always_ff @(posedge clk_pixel) begin
        if (sample_hit) begin
            s1_addr   <= sample_addr;
            s1_detect <= detect_in;
            s1_first  <= (frame_q == '0);
            s1_plane0 <= (plane_q == '0);
            s1_old    <= (s1_valid && (s1_addr == sample_addr)) ? s1_new : mem[sample_addr];
        end
    end

    // Cycle 1 of the RMW: form the new word. Plane 0 ignores the stale
    // contents so the store never needs clearing between runs.
    always_comb begin
        s1_new = s1_old;
        if (s1_first) begin
            if (s1_plane0) begin
                s1_new = {{(W-1){1'b0}}, s1_detect};
            end else begin
                s1_new = {s1_old[W-2:0], s1_detect};
            end
        end else begin
`ifdef CALIB_AND_VOTE_EN
            s1_new[0] = s1_old[0] & s1_detect;
`else
            s1_new[0] = s1_old[0] | s1_detect;
`endif
        end
    end

    // A write pending when rst is high is dropped.
    always_ff @(posedge clk_pixel) begin
        if (s1_valid && !rst) begin
            mem[s1_addr] <= s1_new;
        end
    end

    // ---------------- Host read port ----------------
    logic         host_accept;
    logic         rd_pend;
    logic [W-1:0] rd_word;
    logic         read_valid_q;
    logic [W-1:0] read_out_q;

    assign host_accept = read_request && ((state_q == IDLE) || (state_q == DONE));

    // The final capture write can land in the first DONE cycle, so the host
    // path forwards it too.
    always_ff @(posedge clk_pixel) begin
        if (host_accept) begin
            rd_word <= (s1_valid && (s1_addr == read_addr)) ? s1_new : mem[read_addr];
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            rd_pend      <= 1'b0;
            read_valid_q <= 1'b0;
            read_out_q   <= '0;
        end else begin
            rd_pend      <= host_accept;
            read_valid_q <= rd_pend;
            if (rd_pend) begin
                read_out_q <= rd_word;
            end
        end
    end

    // ---------------- Outputs ----------------
    assign state         = state_q;
    assign plane_idx     = plane_q;
    assign plane_request = plane_request_q;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = done_q;
    assign read_valid    = read_valid_q;
    assign read_out      = read_out_q;

endmodule
